failed_clause_counter: RTL and testbench

Upstream stage of the probabilistic-search acceptance path. It scans the clause evaluator once per proposal, counting failed clauses under the current assignment (u) and under the proposed assignment (v). It then presents the two counts, with a done pulse, to calculateProbability's in_u/in_v inputs. Output count widths match calculateProbability exactly, so the two connect without width adaptation.

---
 rtl/failed_clause_counter_pkg.sv | 15 +
 rtl/clause_fail_accumulator.sv | 22 ++
 rtl/failed_clause_counter.sv | 97 +++++++++
 tb/tb_failed_clause_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/failed_clause_counter_pkg.sv
// Shared widths and FSM encoding for the failed-clause scan stage.
// COUNT_WIDTH must track calculateProbability's in_u/in_v width.
package failed_clause_counter_pkg;

  localparam int unsigned MAX_BIT_WIDTH_OF_CLAUSES_INDEX = 3;
  localparam int unsigned COUNT_WIDTH = MAX_BIT_WIDTH_OF_CLAUSES_INDEX + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/clause_fail_accumulator.sv
// Counts evaluator results that report an unsatisfied clause.
// The register doubles as the externally visible failure count.
module clause_fail_accumulator
  import failed_clause_counter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   sample,
  input  logic                   sat,
  output logic [COUNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (sample && !sat) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/failed_clause_counter.sv
// Scans clauses 0..N-1 once per proposal and counts failures under the
// current (u) and proposed (v) assignments for calculateProbability.
module failed_clause_counter
  import failed_clause_counter_pkg::*;
(
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_start,
  input  logic [COUNT_WIDTH-1:0] in_clause_count,
  input  logic                   in_clause_sat_current,
  input  logic                   in_clause_sat_proposed,
  output logic [COUNT_WIDTH-1:0] out_clause_index,
  output logic                   out_index_valid,
  output logic                   out_busy,
  output logic                   out_done,
  output logic [COUNT_WIDTH-1:0] out_u,
  output logic [COUNT_WIDTH-1:0] out_v
);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] last_index;
  logic                   sample_en;
  logic                   start_accept;

  assign start_accept = (state == IDLE) && in_start;

  // Sat inputs lag the issued index by one cycle, so the sampling
  // enable is simply the index-valid flag delayed by one cycle.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state            <= IDLE;
      out_clause_index <= '0;
      out_index_valid  <= 1'b0;
      out_busy         <= 1'b0;
      out_done         <= 1'b0;
      last_index       <= '0;
      sample_en        <= 1'b0;
    end else begin
      out_done  <= 1'b0;
      sample_en <= out_index_valid;
      case (state)
        IDLE: begin
          if (in_start) begin
            if (in_clause_count != '0) begin
              state            <= SCAN;
              out_clause_index <= '0;
              out_index_valid  <= 1'b1;
              out_busy         <= 1'b1;
              last_index       <= in_clause_count - COUNT_WIDTH'(1);
            end else begin
              state    <= DONE;
              out_done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (out_clause_index == last_index) begin
            state           <= DRAIN;
            out_index_valid <= 1'b0;
          end else begin
            out_clause_index <= out_clause_index + COUNT_WIDTH'(1);
          end
        end
        DRAIN: begin
          state    <= DONE;
          out_busy <= 1'b0;
          out_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  clause_fail_accumulator u_acc_u (
    .clk    (in_clock),
    .reset  (in_reset),
    .clear  (start_accept),
    .sample (sample_en),
    .sat    (in_clause_sat_current),
    .count  (out_u)
  );

  clause_fail_accumulator u_acc_v (
    .clk    (in_clock),
    .reset  (in_reset),
    .clear  (start_accept),
    .sample (sample_en),
    .sat    (in_clause_sat_proposed),
    .count  (out_v)
  );

endmodule

// File: tb/tb_failed_clause_counter.sv
// Directed bench for failed_clause_counter with a 1-cycle evaluator model.
module tb_failed_clause_counter;

  logic       clk = 1'b0;
  logic       in_reset;
  logic       in_start;
  logic [3:0] in_clause_count;
  logic       in_sat_cur;
  logic       in_sat_pro;
  logic [3:0] out_clause_index;
  logic       out_index_valid;
  logic       out_busy;
  logic       out_done;
  logic [3:0] out_u;
  logic [3:0] out_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  failed_clause_counter dut (
    .in_clock               (clk),
    .in_reset               (in_reset),
    .in_start               (in_start),
    .in_clause_count        (in_clause_count),
    .in_clause_sat_current  (in_sat_cur),
    .in_clause_sat_proposed (in_sat_pro),
    .out_clause_index       (out_clause_index),
    .out_index_valid        (out_index_valid),
    .out_busy               (out_busy),
    .out_done               (out_done),
    .out_u                  (out_u),
    .out_v                  (out_v)
  );

  // One scan: start, cycle-by-cycle protocol checks, final counts, idle hold.
  task automatic run_scan(input int n, input logic [15:0] pc, input logic [15:0] pp,
                          input logic [3:0] eu, input logic [3:0] ev, input bit inject,
                          input string name);
    int   last;
    bit   prev_valid;
    int   prev_idx;
    logic exp_valid;
    logic exp_busy;
    logic exp_done;
    last = (n == 0) ? 1 : n + 2;
    prev_valid = 1'b0;
    prev_idx = 0;
    @(posedge clk); #1;
    in_start = 1'b1;
    in_clause_count = 4'(n);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      in_start = 1'b0;
      if (inject && (c == 2 || c == last)) begin
        in_start = 1'b1;
        in_clause_count = 4'd1;
      end
      exp_valid = (c <= n);
      exp_busy = (n > 0) && (c <= n + 1);
      exp_done = (c == last);
      checks++;
      if (out_index_valid !== exp_valid) begin
        failures++;
        $display("FAIL %s valid c=%0d got=%b exp=%b", name, c, out_index_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (out_clause_index !== 4'(c - 1)) begin
          failures++;
          $display("FAIL %s index c=%0d got=%0d exp=%0d", name, c, out_clause_index, c - 1);
        end
      end
      checks++;
      if (out_busy !== exp_busy) begin
        failures++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, out_busy, exp_busy);
      end
      checks++;
      if (out_done !== exp_done) begin
        failures++;
        $display("FAIL %s done c=%0d got=%b exp=%b", name, c, out_done, exp_done);
      end
      in_sat_cur = prev_valid ? pc[prev_idx] : 1'b1;
      in_sat_pro = prev_valid ? pp[prev_idx] : 1'b1;
      prev_valid = out_index_valid;
      prev_idx = int'(out_clause_index);
    end
    checks++;
    if (out_u !== eu || out_v !== ev) begin
      failures++;
      $display("FAIL %s counts got u=%0d v=%0d exp u=%0d v=%0d", name, out_u, out_v, eu, ev);
    end
    @(posedge clk); #1;
    in_start = 1'b0;
    in_sat_cur = 1'b0;
    in_sat_pro = 1'b0;
    checks++;
    if (out_done !== 1'b0 || out_busy !== 1'b0 || out_index_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after got done=%b busy=%b valid=%b exp all 0", name,
               out_done, out_busy, out_index_valid);
    end
    checks++;
    if (out_u !== eu || out_v !== ev) begin
      failures++;
      $display("FAIL %s hold got u=%0d v=%0d exp u=%0d v=%0d", name, out_u, out_v, eu, ev);
    end
    in_sat_cur = 1'b1;
    in_sat_pro = 1'b1;
  endtask

  task automatic test_reset();
    in_reset = 1'b1;
    in_start = 1'b0;
    in_clause_count = 4'd0;
    in_sat_cur = 1'b1;
    in_sat_pro = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_reset = 1'b0;
    checks++;
    if (out_clause_index !== 4'd0 || out_index_valid !== 1'b0 || out_busy !== 1'b0 ||
        out_done !== 1'b0 || out_u !== 4'd0 || out_v !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got idx=%0d valid=%b busy=%b done=%b u=%0d v=%0d exp all 0",
               out_clause_index, out_index_valid, out_busy, out_done, out_u, out_v);
    end
  endtask

  task automatic test_basic();
    // cur 1,0,1,1,0 -> 2 fails; prop 0,0,1,0,0 -> 4 fails
    run_scan(5, 16'h000D, 16'h0004, 4'd2, 4'd4, 1'b0, "basic_n5");
  endtask

  task automatic test_zero();
    run_scan(0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, "zero_n0");
  endtask

  task automatic test_full();
    run_scan(15, 16'h0000, 16'h0000, 4'd15, 4'd15, 1'b0, "full_n15");
  endtask

  task automatic test_ignore_start();
    // cur 0,1,1 -> 1 fail; prop 0,0,0 -> 3 fails; starts in SCAN and DONE dropped
    run_scan(3, 16'h0006, 16'h0000, 4'd1, 4'd3, 1'b1, "ignore_start");
    run_scan(0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1, "ignore_start_n0");
  endtask

  task automatic test_reset_mid_scan();
    bit seen_done;
    seen_done = 1'b0;
    @(posedge clk); #1;
    in_start = 1'b1;
    in_clause_count = 4'd8;
    in_sat_cur = 1'b0;
    in_sat_pro = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      in_start = 1'b0;
      if (out_done) seen_done = 1'b1;
    end
    in_reset = 1'b1;
    @(posedge clk); #1;
    in_reset = 1'b0;
    checks++;
    if (out_clause_index !== 4'd0 || out_index_valid !== 1'b0 || out_busy !== 1'b0 ||
        out_done !== 1'b0 || out_u !== 4'd0 || out_v !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset got idx=%0d valid=%b busy=%b done=%b u=%0d v=%0d exp all 0",
               out_clause_index, out_index_valid, out_busy, out_done, out_u, out_v);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_done || out_busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_done got activity=%b exp=0", seen_done);
    end
    in_sat_cur = 1'b1;
    in_sat_pro = 1'b1;
    // cur 1,0 -> 1 fail; prop 1,1 -> 0 fails
    run_scan(2, 16'h0001, 16'h0003, 4'd1, 4'd0, 1'b0, "after_reset_n2");
  endtask

  task automatic test_chained();
    // u=3, v=1 is the operand pair handed to calculateProbability
    run_scan(4, 16'h0008, 16'h000B, 4'd3, 4'd1, 1'b0, "chained_u3_v1");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_full();
    test_ignore_start();
    test_reset_mid_scan();
    test_chained();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
